axi4lite_fir_driver: RTL and testbench
======================================

// Module: axi4lite_fir_driver
// PURPOSE
//  AXI4-Lite master that drives the memory-mapped FIR filter slave from a local sample stream.
//  Loads the tap count and coefficients, then runs one cycle per sample: write sample, poll done, read result.
//  Delivers each filtered result on an output stream. Sits between a sample source and the FIR slave's AXI port.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  14   AXI address width (matches slave)
//  C_M_AXI_DATA_WIDTH  32   AXI data width
//  FIR_DATA_WIDTH      16   sample/coef/result width
//  FIR_ADDR_WIDTH       6   sample/coef index width
//  POLL_LIMIT        1023   max done-polls per sample (used only with FIR_DRV_TIMEOUT_EN)
// PORTS
//  M_AXI_ACLK     in   1   clock
//  M_AXI_ARESET   in   1   reset, synchronous, active-high
//  cfg_start      in   1   pulse: begin config load
//  cfg_len        in   FIR_ADDR_WIDTH   tap count / circular buffer length, sampled on cfg_start
//  coef_valid/coef_ready  in/out 1   coefficient stream handshake
//  coef_data      in   FIR_DATA_WIDTH   signed coefficient
//  smp_valid/smp_ready    in/out 1   input sample stream handshake
//  smp_data       in   FIR_DATA_WIDTH   signed sample
//  res_valid/res_ready    out/in 1   result stream handshake
//  res_data       out  FIR_DATA_WIDTH   signed filtered result
//  busy           out  1   FSM not in IDLE
//  err            out  1   sticky: non-OKAY BRESP/RRESP (or poll timeout); cleared by reset or cfg_start
//  M_AXI_AW*/W*/B*/AR*/R*  full AXI4-Lite master channel set; AWPROT/ARPROT=0, WSTRB=4'hF
// BEHAVIOUR
//  Reset: all VALID/READY outputs 0, res_data=0, busy=0, err=0, idx=0, FSM=IDLE; one edge aborts any transfer.
//  Map: input RAM 0x0000+(i<<2); coef RAM 0x0800+(i<<2); result 0x1000; done 0x1004 (clear-on-read); length 0x1008.
//  Write: AWVALID and WVALID asserted together, each held until its own READY; then BREADY=1 until BVALID.
//  Read: ARVALID held until ARREADY; then RREADY=1 until RVALID; RDATA captured on that edge.
//  Writes are zero-extended to 32b; result = RDATA[FIR_DATA_WIDTH-1:0] (slave sign-extends).
//  FSM: IDLE -> WR_LEN -> WR_COEF (x cfg_len) -> IDLE; IDLE -> WR_SMP -> POLL -> RD_RES -> OUT -> IDLE.
//   IDLE: cfg_start has priority over smp_valid in the same cycle; smp_ready=1 only in IDLE once configured.
//   WR_COEF: coef_ready=1 for one cycle per accepted coef, then write; coef index 0..cfg_len-1.
//   WR_SMP: write sample at idx; idx increments on B, wraps to 0 after cfg_len-1.
//   POLL: read 0x1004 repeatedly; RDATA[0]=1 -> RD_RES, else reissue AR next cycle.
//   OUT: res_valid=1 held until res_ready; res_data stable while valid.
//  Loading a coefficient zeroes the matching input slot in the slave; cfg_start therefore also resets idx to 0.
//  cfg_start outside IDLE ignored. smp_valid before first config: smp_ready stays 0.
//  cfg_len=0: treated as 1.
//  Error response: err set, transaction completes normally, FSM continues.
//  Latency: min sample-in to res_valid = write + >=1 poll + read, each >=2 cycles.
// CONFIGURATION
//  FIR_DRV_TIMEOUT_EN defined: counts polls per sample; at POLL_LIMIT, sets err, skips RD_RES, returns to IDLE (no result).
//  Undefined: POLL waits indefinitely; no counter logic.
// STRUCTURE
//  Package fir_axi_pkg: address constants (FIR_IN_BASE, FIR_COEF_BASE, FIR_RES_ADDR, FIR_DONE_ADDR, FIR_LEN_ADDR), state enum, OKAY code.
//  One sub-module: axi4lite_master_port -- single-outstanding read/write engine (req/addr/wdata in, done/rdata/resp out).
//  The FSM and counters stay in the top module.
// TESTING
//  Reset mid AW handshake (AWVALID=1, AWREADY=0) -> next cycle all VALIDs 0, busy=0, err=0.
//  cfg_len=4, coefs {16384,0,0,0} -> writes 0x1008=4, then 0x0800..0x080C in order, busy drops after last B.
//  smp 100 with slave done after 3 polls -> exactly 3 reads of 0x1004, 1 read of 0x1000, res_data=50 held until res_ready.
//  5 samples with cfg_len=4 -> AWADDR 0x0000,0x0004,0x0008,0x000C,0x0000 (wrap).
//  BRESP=2'b10 on a sample write -> err=1 sticky, flow still completes, err cleared by next cfg_start.
//  FIR_DRV_TIMEOUT_EN, POLL_LIMIT=8, done never set -> 8 polls, err=1, no res_valid, FSM back in IDLE.

Source files
------------

// File: rtl/fir_axi_pkg.sv
// ============================================================================
// Module  : fir_axi_pkg
// Brief   : Register map, response codes and state encodings for the FIR
//           AXI4-Lite driver and its master port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_axi_pkg;

  localparam logic [13:0] FIR_IN_BASE   = 14'h0000;
  localparam logic [13:0] FIR_COEF_BASE = 14'h0800;
  localparam logic [13:0] FIR_RES_ADDR  = 14'h1000;
  localparam logic [13:0] FIR_DONE_ADDR = 14'h1004;
  localparam logic [13:0] FIR_LEN_ADDR  = 14'h1008;

  localparam logic [1:0] c_resp_okay = 2'b00;

  typedef logic [2:0] drv_state_t;

  localparam drv_state_t c_st_idle    = 3'd0;
  localparam drv_state_t c_st_wr_len  = 3'd1;
  localparam drv_state_t c_st_wr_coef = 3'd2;
  localparam drv_state_t c_st_wr_smp  = 3'd3;
  localparam drv_state_t c_st_poll    = 3'd4;
  localparam drv_state_t c_st_rd_res  = 3'd5;
  localparam drv_state_t c_st_out     = 3'd6;

  localparam logic [2:0] c_mp_idle  = 3'd0;
  localparam logic [2:0] c_mp_waddr = 3'd1;
  localparam logic [2:0] c_mp_wresp = 3'd2;
  localparam logic [2:0] c_mp_raddr = 3'd3;
  localparam logic [2:0] c_mp_rdata = 3'd4;

endpackage

`default_nettype wire

// File: rtl/axi4lite_master_port.sv
// ============================================================================
// Module  : axi4lite_master_port
// Brief   : Single-outstanding AXI4-Lite read/write engine; one req pulse in,
//           one done pulse out carrying the response and read data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_master_port
  import fir_axi_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESET,
  input  logic                i_wr_req,
  input  logic                i_rd_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_done,
  output logic [DATA_W-1:0]   o_rdata,
  output logic [1:0]          o_resp,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = {(DATA_W/8){1'b1}};
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state   <= c_mp_idle;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      o_done    <= 1'b0;
      o_rdata   <= '0;
      o_resp    <= c_resp_okay;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        c_mp_idle: begin
          if (i_wr_req) begin
            r_addr    <= i_addr;
            r_wdata   <= i_wdata;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= c_mp_waddr;
          end else if (i_rd_req) begin
            r_addr    <= i_addr;
            r_arvalid <= 1'b1;
            r_state   <= c_mp_raddr;
          end
        end
        c_mp_waddr: begin
          // AW and W complete independently; B opens once both are gone
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY)) begin
            r_bready <= 1'b1;
            r_state  <= c_mp_wresp;
          end
        end
        c_mp_wresp: begin
          if (M_AXI_BVALID) begin
            r_bready <= 1'b0;
            o_resp   <= M_AXI_BRESP;
            o_done   <= 1'b1;
            r_state  <= c_mp_idle;
          end
        end
        c_mp_raddr: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= c_mp_rdata;
          end
        end
        c_mp_rdata: begin
          if (M_AXI_RVALID) begin
            r_rready <= 1'b0;
            o_rdata  <= M_AXI_RDATA;
            o_resp   <= M_AXI_RRESP;
            o_done   <= 1'b1;
            r_state  <= c_mp_idle;
          end
        end
        default: r_state <= c_mp_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi4lite_fir_driver.sv
// ============================================================================
// Module  : axi4lite_fir_driver
// Brief   : AXI4-Lite master loading taps/coefs into the FIR slave, then per
//           sample: write, poll done, read result, emit on result stream.
//           Optional FIR_DRV_TIMEOUT_EN bounds done-polling to POLL_LIMIT.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_fir_driver
  import fir_axi_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 14,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int FIR_DATA_WIDTH     = 16,
  parameter int FIR_ADDR_WIDTH     = 6,
  parameter int POLL_LIMIT         = 1023
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cfg_start,
  input  logic [FIR_ADDR_WIDTH-1:0]       cfg_len,
  input  logic                            coef_valid,
  output logic                            coef_ready,
  input  logic [FIR_DATA_WIDTH-1:0]       coef_data,
  input  logic                            smp_valid,
  output logic                            smp_ready,
  input  logic [FIR_DATA_WIDTH-1:0]       smp_data,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [FIR_DATA_WIDTH-1:0]       res_data,
  output logic                            busy,
  output logic                            err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  drv_state_t                r_state;
  logic [FIR_ADDR_WIDTH-1:0] r_len;
  logic [FIR_ADDR_WIDTH-1:0] r_idx;
  logic [FIR_ADDR_WIDTH-1:0] r_cidx;
  logic [FIR_DATA_WIDTH-1:0] r_coef;
  logic [FIR_DATA_WIDTH-1:0] r_smp;
  logic [FIR_DATA_WIDTH-1:0] r_res;
  logic                      r_have_coef;
  logic                      r_issued;
  logic                      r_cfg_ok;
  logic                      r_err;

  logic                      w_wr_req;
  logic                      w_rd_req;
  logic [AW-1:0]             w_addr;
  logic [DW-1:0]             w_wdata;
  logic                      w_done;
  logic [DW-1:0]             w_rdata;
  logic [1:0]                w_resp;
  logic [FIR_ADDR_WIDTH-1:0] w_last_idx;
  logic                      w_poll_last;
  logic                      w_unused;

  assign w_last_idx = r_len - FIR_ADDR_WIDTH'(1);
  assign w_unused   = &{1'b0, w_rdata[DW-1:FIR_DATA_WIDTH]};

  assign busy       = (r_state != c_st_idle);
  assign err        = r_err;
  assign res_valid  = (r_state == c_st_out);
  assign res_data   = r_res;
  assign coef_ready = (r_state == c_st_wr_coef) && !r_have_coef;
  assign smp_ready  = (r_state == c_st_idle) && r_cfg_ok && !cfg_start;

  if (POLL_LIMIT < 1) begin : g_poll_limit_check
  end

`ifdef FIR_DRV_TIMEOUT_EN
  localparam int POLL_CNT_W = $clog2(POLL_LIMIT + 1);

  logic [POLL_CNT_W-1:0] r_poll_cnt;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET || (r_state != c_st_poll)) begin
      r_poll_cnt <= '0;
    end else if (w_done) begin
      r_poll_cnt <= r_poll_cnt + POLL_CNT_W'(1);
    end
  end

  assign w_poll_last = (r_poll_cnt == POLL_CNT_W'(POLL_LIMIT - 1));
`else
  assign w_poll_last = 1'b0;
`endif

  always_comb begin
    w_wr_req = 1'b0;
    w_rd_req = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    case (r_state)
      c_st_wr_len: begin
        w_wr_req = !r_issued;
        w_addr   = AW'(FIR_LEN_ADDR);
        w_wdata  = DW'(r_len);
      end
      c_st_wr_coef: begin
        w_wr_req = r_have_coef && !r_issued;
        w_addr   = AW'(FIR_COEF_BASE) + AW'({r_cidx, 2'b00});
        w_wdata  = DW'(r_coef);
      end
      c_st_wr_smp: begin
        w_wr_req = !r_issued;
        w_addr   = AW'(FIR_IN_BASE) + AW'({r_idx, 2'b00});
        w_wdata  = DW'(r_smp);
      end
      c_st_poll: begin
        w_rd_req = !r_issued;
        w_addr   = AW'(FIR_DONE_ADDR);
      end
      c_st_rd_res: begin
        w_rd_req = !r_issued;
        w_addr   = AW'(FIR_RES_ADDR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state     <= c_st_idle;
      r_len       <= FIR_ADDR_WIDTH'(1);
      r_idx       <= '0;
      r_cidx      <= '0;
      r_coef      <= '0;
      r_smp       <= '0;
      r_res       <= '0;
      r_have_coef <= 1'b0;
      r_issued    <= 1'b0;
      r_cfg_ok    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_wr_req || w_rd_req) r_issued <= 1'b1;
      if (w_done && (w_resp != c_resp_okay)) r_err <= 1'b1;

      case (r_state)
        c_st_idle: begin
          // Loading coefs zeroes the slave's input slots, so restart idx too
          if (cfg_start) begin
            r_len    <= (cfg_len == '0) ? FIR_ADDR_WIDTH'(1) : cfg_len;
            r_idx    <= '0;
            r_cidx   <= '0;
            r_err    <= 1'b0;
            r_cfg_ok <= 1'b0;
            r_state  <= c_st_wr_len;
          end else if (smp_valid && r_cfg_ok) begin
            r_smp   <= smp_data;
            r_state <= c_st_wr_smp;
          end
        end
        c_st_wr_len: begin
          if (w_done) begin
            r_issued <= 1'b0;
            r_state  <= c_st_wr_coef;
          end
        end
        c_st_wr_coef: begin
          if (coef_ready && coef_valid) begin
            r_coef      <= coef_data;
            r_have_coef <= 1'b1;
          end
          if (w_done) begin
            r_have_coef <= 1'b0;
            r_issued    <= 1'b0;
            if (r_cidx == w_last_idx) begin
              r_cfg_ok <= 1'b1;
              r_state  <= c_st_idle;
            end else begin
              r_cidx <= r_cidx + FIR_ADDR_WIDTH'(1);
            end
          end
        end
        c_st_wr_smp: begin
          if (w_done) begin
            r_issued <= 1'b0;
            r_idx    <= (r_idx == w_last_idx) ? '0 : r_idx + FIR_ADDR_WIDTH'(1);
            r_state  <= c_st_poll;
          end
        end
        c_st_poll: begin
          if (w_done) begin
            r_issued <= 1'b0;
            if (w_rdata[0]) begin
              r_state <= c_st_rd_res;
            end else if (w_poll_last) begin
              r_err   <= 1'b1;
              r_state <= c_st_idle;
            end
          end
        end
        c_st_rd_res: begin
          if (w_done) begin
            r_issued <= 1'b0;
            r_res    <= w_rdata[FIR_DATA_WIDTH-1:0];
            r_state  <= c_st_out;
          end
        end
        c_st_out: begin
          if (res_ready) r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  axi4lite_master_port #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_port (
    .M_AXI_ACLK    (M_AXI_ACLK),
    .M_AXI_ARESET  (M_AXI_ARESET),
    .i_wr_req      (w_wr_req),
    .i_rd_req      (w_rd_req),
    .i_addr        (w_addr),
    .i_wdata       (w_wdata),
    .o_done        (w_done),
    .o_rdata       (w_rdata),
    .o_resp        (w_resp),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARPROT  (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_fir_driver.sv
// ============================================================================
// Module  : tb_axi4lite_fir_driver
// Brief   : Directed self-checking bench with a behavioural FIR slave model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi4lite_fir_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [5:0]  cfg_len = '0;
  logic        coef_valid = 1'b0, coef_ready;
  logic [15:0] coef_data = '0;
  logic        smp_valid = 1'b0, smp_ready;
  logic [15:0] smp_data = '0;
  logic        res_valid, res_ready = 1'b0;
  logic [15:0] res_data;
  logic        busy, err;
  logic [13:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi4lite_fir_driver #(
    .C_M_AXI_ADDR_WIDTH(14), .C_M_AXI_DATA_WIDTH(32), .FIR_DATA_WIDTH(16),
    .FIR_ADDR_WIDTH(6), .POLL_LIMIT(8)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Slave model knobs, written only by the stimulus block
  logic        hold_aw = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  int          done_after = 1;
  logic [15:0] res_val = '0;

  logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
  logic [13:0] s_awaddr = '0, s_araddr = '0;
  logic [31:0] s_wdata = '0;
  int          polls = 0;
  int          n_wr = 0, n_rd = 0, resv_cycles = 0;
  logic [13:0] wr_addr_log [0:255];
  logic [31:0] wr_data_log [0:255];
  logic [13:0] rd_addr_log [0:255];

  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
  end

  always @(posedge clk) begin
    if (res_valid) resv_cycles <= resv_cycles + 1;
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
      arready <= 1'b0; rvalid <= 1'b0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
    end else begin
      if (awready && awvalid) begin
        awready <= 1'b0; aw_got <= 1'b1; s_awaddr <= awaddr;
      end else if (awvalid && !aw_got && !hold_aw) awready <= 1'b1;
      if (wready && wvalid) begin
        wready <= 1'b0; w_got <= 1'b1; s_wdata <= wdata;
      end else if (wvalid && !w_got) wready <= 1'b1;
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1; bresp <= bresp_cfg;
        wr_addr_log[n_wr] <= s_awaddr; wr_data_log[n_wr] <= s_wdata; n_wr <= n_wr + 1;
        if (s_awaddr < 14'h0800) polls <= 0;
      end
      if (arready && arvalid) begin
        arready <= 1'b0; ar_got <= 1'b1; s_araddr <= araddr;
      end else if (arvalid && !ar_got) arready <= 1'b1;
      if (rvalid && rready) begin
        rvalid <= 1'b0; ar_got <= 1'b0;
      end else if (ar_got && !rvalid) begin
        rvalid <= 1'b1; rresp <= 2'b00;
        rd_addr_log[n_rd] <= s_araddr; n_rd <= n_rd + 1;
        if (s_araddr == 14'h1004) begin
          rdata <= (polls + 1 >= done_after) ? 32'd1 : 32'd0;
          polls <= polls + 1;
        end else if (s_araddr == 14'h1000) rdata <= {{16{res_val[15]}}, res_val};
        else rdata <= '0;
      end
    end
  end

  int n_pass = 0, n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_coef(input logic [15:0] d);
    int n = 0;
    coef_valid = 1'b1; coef_data = d;
    while (!coef_ready && n < 200) begin tick(1); n++; end
    chk("coef_handshake", 32'(n < 200), 32'd1);
    tick(1); coef_valid = 1'b0;
  endtask

  task automatic send_smp(input logic [15:0] d, input int dn, input logic [15:0] r);
    int n = 0;
    done_after = dn; res_val = r;
    smp_valid = 1'b1; smp_data = d;
    while (!smp_ready && n < 200) begin tick(1); n++; end
    chk("smp_handshake", 32'(n < 200), 32'd1);
    tick(1); smp_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 2000) begin tick(1); n++; end
    chk("res_valid_arrives", 32'(res_valid), 32'd1);
  endtask

  task automatic accept_res();
    res_ready = 1'b1; tick(1); res_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin tick(1); n++; end
    chk("returns_idle", 32'(busy), 32'd0);
  endtask

  task automatic start_cfg(input logic [5:0] len);
    cfg_len = len; cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bw, br, n;
    logic [13:0] exp_addr [0:4];
    logic [15:0] smp_vals [0:4];
    logic [15:0] res_vals [0:4];
    exp_addr = '{14'h0000, 14'h0004, 14'h0008, 14'h000C, 14'h0000};
    smp_vals = '{16'd100, 16'd200, 16'hFFF2, 16'd7, 16'd9};
    res_vals = '{16'd50, 16'd100, 16'hFFF9, 16'd3, 16'd4};

    tick(3);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_bready_rready", 32'({bready, rready}), 0);
    chk("rst_busy_err", 32'({busy, err}), 0);
    chk("rst_res", 32'({res_valid, res_data}), 0);
    chk("rst_ready_outs", 32'({coef_ready, smp_ready}), 0);
    rst = 1'b0; tick(1);

    smp_valid = 1'b1; tick(3);
    chk("unconfigured_smp_ready", 32'(smp_ready), 0);
    chk("unconfigured_busy", 32'(busy), 0);
    smp_valid = 1'b0;

    // Reset while AW is stalled
    hold_aw = 1'b1;
    start_cfg(6'd4);
    n = 0;
    while (!awvalid && n < 50) begin tick(1); n++; end
    chk("aw_stalled", 32'({awvalid, awready}), 32'b10);
    chk("aw_len_addr", 32'(awaddr), 32'h1008);
    rst = 1'b1; tick(1);
    chk("midrst_valids", 32'({awvalid, wvalid, arvalid}), 0);
    chk("midrst_busy_err", 32'({busy, err}), 0);
    rst = 1'b0; hold_aw = 1'b0; tick(1);

    // Configuration load
    bw = n_wr;
    start_cfg(6'd4);
    chk("cfg_busy", 32'(busy), 1);
    send_coef(16'd16384); send_coef(16'd0); send_coef(16'd0); send_coef(16'd0);
    wait_idle();
    chk("cfg_write_count", 32'(n_wr - bw), 32'd5);
    chk("cfg_len_addr", 32'(wr_addr_log[bw]), 32'h1008);
    chk("cfg_len_data", wr_data_log[bw], 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cfg_coef_addr", 32'(wr_addr_log[bw+1+i]), 32'h0800 + 32'(i*4));
    end
    chk("cfg_coef0_data", wr_data_log[bw+1], 32'd16384);
    chk("cfg_strb_prot", 32'({wstrb, awprot, arprot}), 32'hF << 6);
    chk("cfg_smp_ready", 32'(smp_ready), 1);

    // First sample: done after 3 polls
    bw = n_wr; br = n_rd;
    send_smp(smp_vals[0], 3, res_vals[0]);
    wait_res();
    chk("s0_read_count", 32'(n_rd - br), 32'd4);
    for (int i = 0; i < 3; i++) chk("s0_poll_addr", 32'(rd_addr_log[br+i]), 32'h1004);
    chk("s0_res_addr", 32'(rd_addr_log[br+3]), 32'h1000);
    chk("s0_smp_addr", 32'(wr_addr_log[bw]), 32'h0000);
    chk("s0_smp_data", wr_data_log[bw], 32'd100);
    chk("s0_res_data", 32'(res_data), 32'd50);
    tick(5);
    chk("s0_held", 32'({res_valid, res_data}), {16'd1, 16'd50});
    accept_res();
    chk("s0_released", 32'({res_valid, busy}), 0);

    for (int i = 1; i < 5; i++) begin
      bw = n_wr;
      send_smp(smp_vals[i], 1, res_vals[i]);
      wait_res();
      chk("wrap_smp_addr", 32'(wr_addr_log[bw]), 32'(exp_addr[i]));
      chk("wrap_smp_data", wr_data_log[bw], 32'(smp_vals[i]));
      chk("wrap_res_data", 32'(res_data), 32'(res_vals[i]));
      accept_res();
    end

    // Error response on a sample write
    bresp_cfg = 2'b10;
    send_smp(16'd5, 1, 16'd33);
    wait_res();
    chk("berr_flag", 32'(err), 1);
    chk("berr_res_data", 32'(res_data), 32'd33);
    accept_res();
    bresp_cfg = 2'b00;
    send_smp(16'd6, 1, 16'd44);
    wait_res();
    chk("berr_sticky", 32'(err), 1);
    accept_res();

    // Reconfigure with cfg_len=0 (treated as 1)
    bw = n_wr;
    start_cfg(6'd0);
    chk("cfg_clears_err", 32'(err), 0);
    send_coef(16'h0123);
    wait_idle();
    chk("len0_write_count", 32'(n_wr - bw), 32'd2);
    chk("len0_len_data", wr_data_log[bw], 32'd1);
    chk("len0_coef_addr", 32'(wr_addr_log[bw+1]), 32'h0800);
    for (int i = 0; i < 2; i++) begin
      bw = n_wr;
      send_smp(16'(i + 1), 1, 16'd1);
      wait_res();
      chk("len1_smp_addr", 32'(wr_addr_log[bw]), 32'h0000);
      accept_res();
    end

`ifdef FIR_DRV_TIMEOUT_EN
    br = n_rd; n = resv_cycles;
    send_smp(16'd11, 100000, 16'd0);
    wait_idle();
    chk("timeout_polls", 32'(n_rd - br), 32'd8);
    chk("timeout_err", 32'(err), 1);
    chk("timeout_no_result", 32'(resv_cycles - n), 0);
`else
    br = n_rd;
    send_smp(16'd11, 100000, 16'd77);
    n = 0;
    while ((n_rd - br) < 20 && n < 2000) begin tick(1); n++; end
    chk("poll_keeps_waiting", 32'({busy, res_valid}), 32'b10);
    done_after = 1;
    wait_res();
    chk("late_done_res", 32'(res_data), 32'd77);
    accept_res();
`endif

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
